// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the addi/bne RV32I subset with a stallable imem fetch.
// Build option: define ILLEGAL_HALT_EN to trap unknown encodings into ERR instead of retiring them as NOPs.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | one cycle after reset release, all outputs quiet
// FETCH   | imem_req high, wait for imem_ready (bounded by MAX_WAIT)
// DECODE  | classify op/funct3 into kind_q
// EXECUTE | ALU/imm word driven, EQ captured into eq_q
// COMMIT  | PC (and for addi the register file) written, retire pulse
// ERR     | fault held until reset, no writes
module multicycle_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       EQ,
  input  logic       imem_ready,
  output logic       imem_req,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCsrc,
  output logic       RegWrite,
  output logic       ALUsrc,
  output logic [2:0] ALUctrl,
  output logic [1:0] ImmSrc,
  output logic       retire,
  output logic       fault
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXECUTE = 3'd3;
  localparam logic [2:0] S_COMMIT  = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  localparam logic [1:0] K_ILLEGAL = 2'd0;
  localparam logic [1:0] K_ADDI    = 2'd1;
  localparam logic [1:0] K_BNE     = 2'd2;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       kind_q, kind_d;
  logic             eq_q, eq_d;
  logic [1:0]       kind_dec;

  always_comb begin
    kind_dec = K_ILLEGAL;
    if (op == 7'b0010011 && funct3 == 3'b000)
      kind_dec = K_ADDI;
    else if (op == 7'b1100011 && funct3 == 3'b001)
      kind_dec = K_BNE;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    eq_d    = eq_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_FETCH: begin
        // a ready arriving on the last allowed wait cycle still wins over the timeout
        if (imem_ready) begin
          state_d = S_DECODE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == WAIT_LAST)
            state_d = S_ERR;
        end
      end
      S_DECODE: begin
        kind_d = kind_dec;
`ifdef ILLEGAL_HALT_EN
        state_d = (kind_dec == K_ILLEGAL) ? S_ERR : S_EXECUTE;
`else
        state_d = S_EXECUTE;
`endif
      end
      S_EXECUTE: begin
        eq_d    = EQ;
        state_d = S_COMMIT;
      end
      S_COMMIT: state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kind_q  <= K_ILLEGAL;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      eq_q    <= eq_d;
    end
  end

  // IRWrite follows imem_ready inside FETCH so the IR captures data on the ready cycle itself
  always_comb begin
    imem_req = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCsrc    = 1'b0;
    RegWrite = 1'b0;
    ALUsrc   = 1'b0;
    ALUctrl  = 3'b000;
    ImmSrc   = 2'b00;
    retire   = 1'b0;
    fault    = 1'b0;
    if (state_q == S_FETCH) begin
      imem_req = 1'b1;
      IRWrite  = imem_ready;
    end
    if (state_q == S_EXECUTE || state_q == S_COMMIT) begin
      if (kind_q == K_ADDI) begin
        ALUsrc = 1'b1;
      end else if (kind_q == K_BNE) begin
        ALUctrl = 3'b001;
        ImmSrc  = 2'b10;
      end
    end
    if (state_q == S_COMMIT) begin
      PCWrite  = 1'b1;
      retire   = 1'b1;
      RegWrite = (kind_q == K_ADDI);
      PCsrc    = (kind_q == K_BNE) && !eq_q;
    end
    if (state_q == S_ERR)
      fault = 1'b1;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected commit words are queued at fetch and popped on retire.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_multicycle_ctrl;

  localparam int MAX_WAIT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       EQ = 1'b0;
  logic       imem_ready = 1'b0;
  logic       imem_req, IRWrite, PCWrite, PCsrc, RegWrite, ALUsrc, retire, fault;
  logic [2:0] ALUctrl;
  logic [1:0] ImmSrc;

  typedef struct packed {
    logic       reg_write;
    logic       pc_src;
    logic       alu_src;
    logic [2:0] alu_ctrl;
    logic [1:0] imm_src;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ir_writes = 0;

  multicycle_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .EQ(EQ), .imem_ready(imem_ready),
    .imem_req(imem_req), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCsrc(PCsrc),
    .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .ImmSrc(ImmSrc),
    .retire(retire), .fault(fault)
  );

  always #5 clk = ~clk;

  wire [12:0] outs = {imem_req, IRWrite, PCWrite, PCsrc, RegWrite, ALUsrc, ALUctrl, ImmSrc, retire, fault};

  function automatic exp_t model(input logic [6:0] o, input logic [2:0] f, input logic eq);
    exp_t e;
    e = '0;
    if (o == 7'h13 && f == 3'b000) begin
      e.reg_write = 1'b1;
      e.alu_src   = 1'b1;
    end else if (o == 7'h63 && f == 3'b001) begin
      e.alu_ctrl = 3'b001;
      e.imm_src  = 2'b10;
      e.pc_src   = !eq;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (IRWrite === 1'b1) ir_writes++;
    checks++;
    if (retire === 1'b1) begin
      exp_t e;
      exp_t got;
      got = {RegWrite, PCsrc, ALUsrc, ALUctrl, ImmSrc};
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL retire_unexpected: retire=1 with nothing pending at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        if (got !== e || PCWrite !== 1'b1) begin
          errors++;
          $display("FAIL commit_word: got %b PCWrite=%b, expected %b PCWrite=1", got, PCWrite, e);
        end
      end
    end else if (PCWrite !== 1'b0 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL write_outside_commit: PCWrite=%b RegWrite=%b, expected 0 0", PCWrite, RegWrite);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b0;
    EQ = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic fetch_instr(input logic [6:0] o, input logic [2:0] f, input logic eq,
                             input int stalls, output int fetch_wait);
    int left;
    bit done;
    left = stalls;
    done = 0;
    fetch_wait = 0;
    while (!done && fetch_wait < 40) begin
      @(posedge clk);
      #1 fetch_wait++;
      if (imem_req === 1'b1) begin
        if (left > 0) begin
          imem_ready = 1'b0;
          left--;
        end else begin
          imem_ready = 1'b1;
          op = o;
          funct3 = f;
          EQ = eq;
          done = 1;
        end
      end else begin
        imem_ready = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (!done || IRWrite !== 1'b1) begin
      errors++;
      $display("FAIL fetch_irwrite: IRWrite=%b done=%0d, expected IRWrite=1", IRWrite, done);
    end
  endtask

  task automatic wait_retire(input logic eq, output int lat);
    lat = 0;
    while (lat < 12) begin
      @(posedge clk);
      #1 lat++;
      if (lat == 3) EQ = ~eq;
      @(negedge clk);
      if (retire === 1'b1) break;
    end
  endtask

  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f,
                           input logic eq, input int stalls);
    int fw, lat, irw0;
    irw0 = ir_writes;
    fetch_instr(o, f, eq, stalls, fw);
    sb_q.push_back(model(o, f, eq));
    checks++;
    if (fw != stalls + 1) begin
      errors++;
      $display("FAIL %s fetch_cycles: got %0d expected %0d", name, fw, stalls + 1);
    end
    wait_retire(eq, lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL %s retire_latency: got %0d expected 3", name, lat);
    end
    #1;
    checks++;
    if (ir_writes - irw0 != 1) begin
      errors++;
      $display("FAIL %s irwrite_count: got %0d expected 1", name, ir_writes - irw0);
    end
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL %s fault: got %b expected 0", name, fault);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_ready = 1'b1;
    op = 7'h13;
    @(negedge clk);
    checks++;
    if (outs !== 13'h0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero", outs);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    imem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 13'h0000) begin
      errors++;
      $display("FAIL idle_outputs: got %b expected all zero", outs);
    end
  endtask

  task automatic test_addi();
    run_instr("addi", 7'h13, 3'b000, 1'b0, 0);
  endtask

  task automatic test_bne();
    run_instr("bne_taken", 7'h63, 3'b001, 1'b0, 0);
    run_instr("bne_not_taken", 7'h63, 3'b001, 1'b1, 0);
  endtask

  task automatic test_stall();
    run_instr("stall3", 7'h13, 3'b000, 1'b1, 3);
    run_instr("stall_edge", 7'h63, 3'b001, 1'b0, MAX_WAIT - 1);
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_0", 7'h63, 3'b001, 1'b1, 0);
    run_instr("b2b_1", 7'h13, 3'b000, 1'b0, 0);
    run_instr("b2b_2", 7'h63, 3'b001, 1'b0, 1);
    run_instr("b2b_3", 7'h13, 3'b010, 1'b0, 0);
  endtask

  task automatic test_illegal();
`ifdef ILLEGAL_HALT_EN
    int fw;
    fetch_instr(7'b0110011, 3'b000, 1'b0, 0, fw);
    @(posedge clk);
    #1;
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL illegal_decode_fault: got %b expected 0", fault);
    end
    @(posedge clk);
    #1;
    checks++;
    if (outs !== 13'h0001) begin
      errors++;
      $display("FAIL illegal_err_outputs: got %b expected 0000000000001", outs);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (fault !== 1'b1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL illegal_sticky: fault=%b pending=%0d expected 1 0", fault, sb_q.size());
    end
    do_reset();
`else
    run_instr("illegal_nop", 7'b0110011, 3'b000, 1'b0, 0);
`endif
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    n = 0;
    imem_ready = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      if (fault === 1'b1) break;
      if (imem_req === 1'b1) n++;
    end
    checks++;
    if (n != MAX_WAIT) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d expected %0d", n, MAX_WAIT);
    end
    checks++;
    if (outs !== 13'h0001) begin
      errors++;
      $display("FAIL timeout_outputs: got %b expected 0000000000001", outs);
    end
    @(posedge clk);
    #1 imem_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== 13'h0001) begin
      errors++;
      $display("FAIL timeout_sticky: got %b expected 0000000000001", outs);
    end
    do_reset();
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL timeout_reset_clear: got %b expected 0", fault);
    end
  endtask

  task automatic test_reset_mid();
    int fw;
    fetch_instr(7'h13, 3'b000, 1'b0, 0, fw);
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (ALUsrc !== 1'b1 || PCWrite !== 1'b0) begin
      errors++;
      $display("FAIL mid_execute_state: ALUsrc=%b PCWrite=%b expected 1 0", ALUsrc, PCWrite);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== 13'h0000) begin
      errors++;
      $display("FAIL mid_reset_async: got %b expected all zero", outs);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 13'h0000) begin
      errors++;
      $display("FAIL mid_reset_idle: got %b expected all zero", outs);
    end
    run_instr("after_abort", 7'h63, 3'b001, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_bne();
    test_stall();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_timeout();
    run_instr("post_timeout", 7'h13, 3'b000, 1'b0, 2);
    repeat (2) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
